store_logic: RTL and testbench
==============================

// Module: store_logic
// PURPOSE
//   Store-path formatter between the ALU and the Data Memory write port.
//   - Takes the store data word (D), the two low address bits from the ALU (ALU) and the store type (DT).
//   - Produces the data to write (ND) and a per-byte write enable (BE).
//   - Supports byte store (sb) and word store (sw).
//   - Outputs are registered: one clock of latency.
// PARAMETERS
//   none   data width fixed at 32 bits, address-offset width fixed at 2 bits.
// PORTS
//   clk    input   1    system clock, rising-edge active
//   rst    input   1    reset, asynchronous, active-high
//   D      input   32   store data from register file (rt)
//   ALU    input   2    byte offset = ALU result [1:0]
//   DT     input   1    data type: 0 = byte store (sb), 1 = word store (sw)
//   ND     output  32   new data to Data Memory (registered)
//   BE     output  4    byte enable, bit i = memory byte lane i (registered)
// BEHAVIOUR
//   - Single clock; reset is asynchronous and active-high.
//   - Reset (rst=1, asynchronous, independent of clk): ND = 32'h0000_0000, BE = 4'b0000.
//     Outputs hold these values while rst is high.
//   - On each rising clk edge with rst=0, ND and BE load the combinational results below.
//     Latency is 1 cycle; no handshake; a new input may be applied every cycle.
//   - Byte store, DT=0:
//       ND = {24'b0, D[7:0]}  (byte always in bits [7:0], zero-extended, NOT lane-shifted)
//       BE = 4'b0001 << ALU
//       ALU=00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000
//   - Word store, DT=1:
//       ALU=00 -> ND = D, BE = 4'b1111.
//       ALU!=00 (misaligned) -> ND = D, BE = 4'b0000 (write suppressed).
//   - D[31:8] is ignored for sb; only D[7:0] reaches ND.
//   - BE is always one-hot (sb), all-ones (aligned sw) or zero (misaligned sw or reset).
//     No other BE pattern is legal.
//   - X/Z on inputs need not be handled; inputs are sampled only at the clk edge.
//   - Reset asserted mid-stream clears outputs immediately.
//     After rst deasserts, the first rising edge loads the current inputs.
// TESTING
//   1. rst=1, D=32'hFFFF_FFFF, DT=1, ALU=00 -> ND=0, BE=0000 immediately and across clk edges.
//   2. D=32'd65535, ALU=11, DT=0, one edge -> ND=32'd255, BE=4'b1000.
//   3. D=32'hA1B2_C3D4, DT=0, ALU=00/01/10 on consecutive edges
//      -> ND=32'h0000_00D4 each cycle; BE=0001, 0010, 0100 in turn.
//   4. D=32'hDEAD_BEEF, DT=1, ALU=00 -> ND=32'hDEAD_BEEF, BE=1111.
//   5. D=32'hDEAD_BEEF, DT=1, ALU=10 -> ND=32'hDEAD_BEEF, BE=0000.
//   6. Assert rst between edges while BE=1000 -> BE=0000, ND=0 without waiting for clk;
//      deassert rst, next edge -> outputs follow inputs.

Source files
------------

// File: rtl/store_logic.sv
// Store-path formatter: turns store data, byte offset and store type into
// registered memory write data and per-lane byte enables (1-cycle latency).
module store_logic (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] D,
    input  logic [1:0]  ALU,
    input  logic        DT,
    output logic [31:0] ND,
    output logic [3:0]  BE
);

    logic [31:0] nd_c;
    logic [3:0]  be_c;

    // Byte data stays in [7:0]; only the enable selects the lane.
    always_comb begin
        nd_c = {24'b0, D[7:0]};
        be_c = 4'b0001 << ALU;
        if (DT) begin
            nd_c = D;
            // Misaligned word stores are dropped by disabling every lane.
            be_c = (ALU == 2'b00) ? 4'b1111 : 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ND <= 32'h0000_0000;
            BE <= 4'b0000;
        end else begin
            ND <= nd_c;
            BE <= be_c;
        end
    end

endmodule

// File: tb/tb_store_logic.sv
// Scoreboard bench for store_logic: driver queues hand-computed results,
// monitor pops one entry after every rising edge and compares.
module tb_store_logic;

    typedef struct {
        logic [31:0] nd;
        logic [3:0]  be;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] D   = 32'hFFFF_FFFF;
    logic [1:0]  ALU = 2'b00;
    logic        DT  = 1'b1;
    logic [31:0] ND;
    logic [3:0]  BE;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    store_logic dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .ALU (ALU),
        .DT  (DT),
        .ND  (ND),
        .BE  (BE)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] exp_nd, input logic [3:0] exp_be);
        n_checks++;
        if (ND !== exp_nd || BE !== exp_be) begin
            n_fails++;
            $display("FAIL %s: got ND=%h BE=%b, expected ND=%h BE=%b", name, ND, BE, exp_nd, exp_be);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] d, input logic [1:0] a, input logic t,
                         input logic [31:0] exp_nd, input logic [3:0] exp_be, input string name);
        exp_t e;
        @(negedge clk);
        rst = r;
        D   = d;
        ALU = a;
        DT  = t;
        e.nd = exp_nd;
        e.be = exp_be;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so consume one entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare(e.name, e.nd, e.be);
            end
        end
    end

    initial begin
        #1;
        compare("reset_immediate", 32'h0, 4'b0000);

        drive(1'b1, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0, 4'b0000, "reset_edge0");
        drive(1'b1, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0, 4'b0000, "reset_edge1");

        drive(1'b0, 32'd65535,     2'b11, 1'b0, 32'd255,       4'b1000, "sb_65535_off3");
        drive(1'b0, 32'hA1B2_C3D4, 2'b00, 1'b0, 32'h0000_00D4, 4'b0001, "sb_off0");
        drive(1'b0, 32'hA1B2_C3D4, 2'b01, 1'b0, 32'h0000_00D4, 4'b0010, "sb_off1");
        drive(1'b0, 32'hA1B2_C3D4, 2'b10, 1'b0, 32'h0000_00D4, 4'b0100, "sb_off2");
        drive(1'b0, 32'h1234_5678, 2'b11, 1'b0, 32'h0000_0078, 4'b1000, "sb_off3");
        drive(1'b0, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'hDEAD_BEEF, 4'b1111, "sw_aligned");
        drive(1'b0, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'hDEAD_BEEF, 4'b0000, "sw_misal2");
        drive(1'b0, 32'h0BAD_F00D, 2'b01, 1'b1, 32'h0BAD_F00D, 4'b0000, "sw_misal1");
        drive(1'b0, 32'h0BAD_F00D, 2'b11, 1'b1, 32'h0BAD_F00D, 4'b0000, "sw_misal3");
        drive(1'b0, 32'hCAFE_0080, 2'b11, 1'b0, 32'h0000_0080, 4'b1000, "sb_before_rst");

        // Assert reset between edges once the previous result has been checked.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("midstream_rst_async", 32'h0, 4'b0000);

        drive(1'b1, 32'hCAFE_0080, 2'b11, 1'b0, 32'h0,         4'b0000, "rst_held_edge");
        drive(1'b0, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'hDEAD_BEEF, 4'b1111, "after_rst_sw");
        drive(1'b0, 32'h0000_00AB, 2'b01, 1'b0, 32'h0000_00AB, 4'b0010, "after_rst_sb");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
